// File: rtl/fsic_wb_pkg.sv
// Shared types and helpers for the FSIC Wishbone slot fabric and its siblings.
package fsic_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Width of a slot index that can also encode "no slot" (value num_slots).
  function automatic int unsigned slot_idx_width(input int unsigned num_slots);
    return $clog2(num_slots + 1);
  endfunction

endpackage

// File: rtl/fsic_wb_slot_fabric_if.sv
// SoC-side Wishbone slave signals plus the fanned-out per-slot master bus.
interface fsic_wb_slot_fabric_if #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_SHIFT = 12
);
  logic [31:0]             wbs_adr;
  logic [31:0]             wbs_wdata;
  logic [3:0]              wbs_sel;
  logic                    wbs_cyc;
  logic                    wbs_stb;
  logic                    wbs_we;
  logic                    wbs_ack;
  logic [31:0]             wbs_rdata;

  logic [NUM_SLOTS-1:0]    m_cyc;
  logic [NUM_SLOTS-1:0]    m_stb;
  logic                    m_we;
  logic [3:0]              m_sel;
  logic [SLOT_SHIFT-1:0]   m_adr;
  logic [31:0]             m_wdata;
  logic [NUM_SLOTS-1:0]    m_ack;
  logic [32*NUM_SLOTS-1:0] m_rdata;

  // The fabric: slave towards the SoC, master towards the slots.
  modport slave (
    input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_ack, wbs_rdata,
    output m_cyc, m_stb, m_we, m_sel, m_adr, m_wdata,
    input  m_ack, m_rdata
  );

  // The environment: SoC master plus the slot slaves.
  modport master (
    output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_ack, wbs_rdata,
    input  m_cyc, m_stb, m_we, m_sel, m_adr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/fsic_wb_slot_decode.sv
// Combinational address decode of the user window into equal-size slot regions.
module fsic_wb_slot_decode
  import fsic_wb_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS  = 4,
  parameter  logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter  int unsigned SLOT_SHIFT = 12,
  localparam int unsigned SW         = slot_idx_width(NUM_SLOTS)
) (
  input  logic [31:0]           adr,
  output logic                  hit,
  output logic [SW-1:0]         slot,
  output logic [SLOT_SHIFT-1:0] offset
);

  localparam logic [32:0] WINDOW = 33'(NUM_SLOTS) << SLOT_SHIFT;

  logic [31:0] off;

  // Window-relative offset; the 33-bit compare keeps a full 4 GiB window exact.
  always_comb begin
    off    = adr - BASE_ADDR;
    hit    = (adr >= BASE_ADDR) && ({1'b0, off} < WINDOW);
    slot   = SW'(off >> SLOT_SHIFT);
    offset = off[SLOT_SHIFT-1:0];
  end

endmodule

// File: rtl/fsic_wb_slot_fabric.sv
// Wishbone front-end: decodes the SoC access, forwards it to one slot at a
// time, registers the reply and bounds every slot wait with a timeout.
module fsic_wb_slot_fabric
  import fsic_wb_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned SLOT_SHIFT = 12,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
  input  logic                               wb_clk,
  input  logic                               wb_rst_n,
  fsic_wb_slot_fabric_if.slave               bus,
  output logic                               err_irq,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     err_slot,
  output logic [7:0]                         err_count
);

  localparam int unsigned SW        = slot_idx_width(NUM_SLOTS);
  localparam logic [9:0]  LAST_WAIT = 10'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [SLOT_SHIFT-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [SW-1:0]         err_slot_d;
  logic [7:0]            err_count_d;

  logic                  dec_hit;
  logic [SW-1:0]         dec_slot;
  logic [SLOT_SHIFT-1:0] dec_offset;
  logic                  sel_ack;
  logic [31:0]           sel_rdata;

  fsic_wb_slot_decode #(
    .NUM_SLOTS  (NUM_SLOTS),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_decode (
    .adr    (bus.wbs_adr),
    .hit    (dec_hit),
    .slot   (dec_slot),
    .offset (dec_offset)
  );

  // Pick ack and read data of the selected slot; other slots are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SW'(i)) begin
        sel_ack   = bus.m_ack[i];
        sel_rdata = bus.m_rdata[32*i +: 32];
      end
    end
  end

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = 1'b0;
    err_slot_d  = err_slot;
    err_count_d = err_count;
    case (state_q)
      IDLE: begin
        if (bus.wbs_cyc && bus.wbs_stb) begin
          if (dec_hit) begin
            slot_d  = dec_slot;
            adr_d   = dec_offset;
            we_d    = bus.wbs_we;
            sel_d   = bus.wbs_sel;
            wdata_d = bus.wbs_wdata;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            data_d      = ERR_DATA;
            err_d       = 1'b1;
            err_slot_d  = SW'(NUM_SLOTS);
            err_count_d = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
            state_d     = RESP;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 10'd1;
        if (sel_ack) begin
          data_d  = we_q ? '0 : sel_rdata;
          state_d = RESP;
        end else if (cnt_q == LAST_WAIT) begin
          data_d      = ERR_DATA;
          err_d       = 1'b1;
          err_slot_d  = slot_q;
          err_count_d = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
          state_d     = RESP;
        end else if (!bus.wbs_cyc) begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_slot  <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_slot  <= err_slot_d;
      err_count <= err_count_d;
    end
  end

  // Outputs decoded from registers only, so no wbs_* to m_* path exists.
  always_comb begin
    bus.m_cyc = '0;
    bus.m_stb = '0;
    if (state_q == REQ) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (slot_q == SW'(i)) begin
          bus.m_cyc[i] = 1'b1;
          bus.m_stb[i] = 1'b1;
        end
      end
    end
    bus.wbs_ack   = (state_q == RESP);
    bus.wbs_rdata = (state_q == RESP) ? data_q : '0;
    err_irq       = (state_q == RESP) && err_q;
  end

  assign bus.m_we    = we_q;
  assign bus.m_sel   = sel_q;
  assign bus.m_adr   = adr_q;
  assign bus.m_wdata = wdata_q;

endmodule

// File: doc/fsic_wb_slot_fabric.md
# fsic_wb_slot_fabric

Parametrised Wishbone slave front-end between the Caravel management SoC and NUM_SLOTS user-project slots, in user_project_wrapper ahead of the FSIC core. Decodes the caravel user address window into equal-size slot regions and forwards one transaction at a time to the selected slot. Registers the response back to the SoC. Guards every access with a wait-state timeout that returns error data, so a hung slot never stalls the management bus.

## Interface
- NUM_SLOTS, 4: number of downstream slots, 1..8.
- BASE_ADDR, 32'h3000_0000: start of decoded window.
- SLOT_SHIFT, 12: log2 of slot region size in bytes.
- TIMEOUT, 255: maximum cycles spent waiting for slot ack, 2..1023.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on decode miss or timeout.
- wb_clk  in  1  sole clock, rising edge.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- wbs_adr / wbs_wdata  in  32 / 32  SoC address / write data.
- wbs_sel  in  4  byte enables.
- wbs_cyc, wbs_stb, wbs_we  in  1 each  SoC cycle, strobe, write enable.
- wbs_ack  out  1  registered ack, one cycle per transaction.
- wbs_rdata  out  32  read data, valid while wbs_ack=1, else 0.
- m_cyc, m_stb  out  NUM_SLOTS  one-hot per-slot cycle/strobe.
- m_we  out  1;  m_sel  out  4;  m_adr  out  SLOT_SHIFT  offset within slot;  m_wdata  out  32  (shared, latched).
- m_ack  in  NUM_SLOTS  per-slot ack.
- m_rdata  in  32*NUM_SLOTS  slot i read data at bits [32i+31:32i].
- err_irq  out  1  one-cycle pulse per error.
- err_slot  out  $clog2(NUM_SLOTS+1)  slot of last error; NUM_SLOTS = decode miss.
- err_count  out  8  saturating error count.

## Operation
- FSM states IDLE, REQ, RESP. Reset: IDLE. All outputs 0, counters 0.
- IDLE: on wbs_cyc&wbs_stb, compute off = wbs_adr - BASE_ADDR.
  - Hit: wbs_adr >= BASE_ADDR and off < NUM_SLOTS<<SLOT_SHIFT. Set slot = off>>SLOT_SHIFT. Latch adr offset, we, sel, wdata. Go REQ.
  - Miss: go RESP with rdata=ERR_DATA. Raise error with err_slot=NUM_SLOTS. A miss on a write still acks, with no side effect.
- REQ: m_cyc[slot]=m_stb[slot]=1, all other bits 0. Wait counter starts at 0 on entry and increments each cycle.
  - m_ack[slot]=1: capture m_rdata[slot] (writes capture 0). Go RESP.
  - Else if counter==TIMEOUT-1: go RESP with ERR_DATA and raise error with err_slot=slot.
  - Else if wbs_cyc=0 (SoC abort): drop m_cyc/m_stb and go IDLE. No ack, no error.
  - Ack of a non-selected slot is ignored.
- RESP: wbs_ack=1 for exactly one cycle. wbs_rdata = captured data. Then go IDLE.
- Error: err_irq pulses in the RESP cycle. err_slot updates. err_count increments, saturating at 255.

## Timing
- Zero-wait slave (combinational m_ack in its first REQ cycle): wbs_stb sampled at edge E0, m_stb high in cycle 1, wbs_ack high in cycle 2.
- Each slave wait state adds 1 cycle.
- Decode miss: wbs_ack in cycle 1.
- Timeout: REQ lasts exactly TIMEOUT cycles, so wbs_ack occurs TIMEOUT+1 cycles after E0.
- m_ack on the final REQ cycle wins over the timeout: real data, no error.
- In IDLE the SoC has already dropped wbs_stb after the ack, so there is no double-accept. Back-to-back throughput is one transaction per 3 cycles minimum.
- All outputs are registered. No combinational path from wbs_* to m_* or back.
- wb_rst_n low at any time: outputs clear immediately and the in-flight transaction is dropped silently. Release is synchronised by the reset tree outside this block.

## Structure
- Shared package fsic_wb_pkg holds:
  - state enum (IDLE, REQ, RESP);
  - default ERR_DATA;
  - slot-index width function (clog2 of NUM_SLOTS+1).
- Sub-module fsic_wb_slot_decode: combinational hit/miss and slot index from address and parameters. It is reused by the later AXI-lite front-end.
- The counter and FSM stay in the top module.

## Test plan
- Read of 0x3000_1004 with NUM_SLOTS=4, slot 1 acking immediately with 0x1234_5678 -> m_stb=4'b0010, m_adr=0x004, wbs_rdata=0x1234_5678 in cycle 2, err_count=0.
- Write 0xA5A5_0001 with sel=4'b0011 to 0x3000_3FFC -> slot 3 sees we=1, m_adr=0xFFC, sel=0011, wdata=0xA5A5_0001; a single wbs_ack.
- Read of 0x3000_4000 (miss) -> wbs_ack in cycle 1, rdata=0xDEAD_BEEF, err_irq pulse, err_slot=4, no m_stb.
- Slot 2 never acks with TIMEOUT=8 -> m_stb[2] high 8 cycles, ack with 0xDEAD_BEEF at cycle 9, err_slot=2. A repeat with m_ack on the 8th cycle gives real data and no error.
- wbs_cyc dropped in the 3rd REQ cycle -> m_cyc=0 next cycle, no wbs_ack, err_count unchanged. The next transaction proceeds normally.
- wb_rst_n asserted mid-REQ -> m_stb, wbs_ack and err_count=0 at once. 300 forced misses -> err_count saturates at 255.
